motor_move_ctrl: RTL and testbench
==================================

Name: motor_move_ctrl

Overview:
- Sequences one positioning move of the click-driven motor: latches the 90/180 target, waits for the error datapath to refresh, then drives enable/direction/duty from errorabs/errorsign until the error stays within tolerance.
- Sits between the user command input and the motor driver, downstream of the position-error block (target 87 for 90, 174 for 180).
- Adds settle detection, timeout fault and abort.

Parameters:
- TOL, 2: errorabs <= TOL counts as on-target.
- SLOW_BAND, 16: errorabs <= SLOW_BAND selects slow duty.
- DUTY_FAST, 255: 8-bit duty outside the slow band.
- DUTY_SLOW, 96: 8-bit duty inside the slow band.
- SETTLE_CYC, 1024: consecutive on-target cycles required for done.
- TIMEOUT_CYC, 24000000: maximum RUN+SETTLE cycles (0.5 s at 48 MHz).
- PIPE_LAT, 2: cycles from target_sel change to valid errorabs/errorsign.

Ports:
- clk_48 in 1: 48 MHz clock.
- reset_n in 1: asynchronous, active-low reset.
- command in 1: asynchronous move request, acted on at its rising edge.
- sel_90 in 1: target select, 1 = 90, 0 = 180; sampled at command accept.
- abort in 1: synchronous stop request, level.
- errorabs in 12: |target - position| from the error block.
- errorsign in 1: 1 = position beyond target, 0 = position short of target.
- target_sel out 1: latched select fed to the error block's EN_180_90.
- motor_en out 1: driver enable.
- motor_dir out 1: 1 = forward (increase position), 0 = reverse.
- duty out 8: PWM duty word.
- busy out 1: high from accept until IDLE/DONE/FAULT.
- done out 1: one-cycle pulse on successful settle.
- fault out 1: sticky timeout flag.

Behaviour:
- Reset values: target_sel=0, motor_en=0, motor_dir=0, duty=0, busy=0, done=0, fault=0; state IDLE; all counters 0.
- command input:
  - Passes through a 2-flop synchronizer followed by a rising-edge detector.
  - An accepted edge is a single-cycle cmd_pulse, 3 cycles after the raw edge.
- IDLE:
  - On cmd_pulse with abort=0: latch target_sel<=sel_90, clear fault, set busy, go to WAIT.
  - A pulse while in any other state is ignored.
- WAIT:
  - Counts PIPE_LAT cycles with the motor off.
  - Then goes to RUN, clearing the timeout and settle counters.
- RUN:
  - Each cycle, if errorabs > TOL: motor_en=1, motor_dir=~errorsign, duty=DUTY_FAST if errorabs > SLOW_BAND, else DUTY_SLOW.
  - If errorabs <= TOL: motor_en=0, duty=0, go to SETTLE.
- SETTLE:
  - Motor off; settle counter increments each cycle errorabs <= TOL.
  - If errorabs > TOL: settle counter clears and state returns to RUN on the next cycle (overshoot re-correction).
  - When the counter reaches SETTLE_CYC-1 with errorabs <= TOL: go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
- Timeout:
  - The timeout counter runs in RUN and SETTLE (25 bits, saturating).
  - On reaching TIMEOUT_CYC-1: motor off, fault=1, busy=0, go to FAULT.
- FAULT:
  - Holds the motor off.
  - cmd_pulse restarts exactly as from IDLE (fault clears on accept).
- abort=1 in any state:
  - Next cycle: motor_en=0, duty=0, busy=0, state IDLE, no done pulse, fault unchanged.
  - abort wins over a simultaneous cmd_pulse and over a simultaneous settle/timeout completion.
- Output timing:
  - All outputs are registered: a state's outputs appear on the cycle after the transition decision.
  - motor_dir holds its last value while motor_en=0.
- Error inputs:
  - Treated as unsigned and ignored outside RUN/SETTLE.
  - errorabs=0 with errorsign=1 counts as on-target.
- Asynchronous reset mid-move: outputs drop immediately to reset values, with no done or fault.

Decomposition:
- Shared package motor_pkg:
  - State encoding (IDLE, WAIT, RUN, SETTLE, DONE, FAULT).
  - Target constants TGT_90=87, TGT_180=174.
  - Default TOL, SLOW_BAND, DUTY_FAST, DUTY_SLOW, 48 MHz cycle constants.
- Sub-module cmd_edge_sync: 2-flop synchronizer plus rising-edge pulse, reusable for other front-panel inputs.
- Counters and the FSM stay in motor_move_ctrl.

Test Plan:
- Basic 90 move:
  - Stimulus: reset; command rise with sel_90=1; errorabs=40, errorsign=0 ramping down by 1 per 100 cycles to 0.
  - Response: target_sel=1; motor_en=1, dir=1, duty=255 until errorabs=16, then 96; motor off at errorabs=2; done pulse after 1024 on-target cycles; busy falls with done.
- Overshoot:
  - Stimulus: in SETTLE at cycle 500, errorabs=5, errorsign=1.
  - Response: back to RUN with dir=0, duty=96; the settle count restarts and done arrives 1024 cycles after the error returns to <=2.
- Timeout:
  - Stimulus: TIMEOUT_CYC=5000 (bench override), errorabs held at 100.
  - Response: after 5000 RUN cycles, fault=1, motor_en=0, busy=0, no done; a new command clears fault and restarts.
- Abort:
  - Stimulus: abort high for 1 cycle mid-RUN.
  - Response: next cycle motor_en=0, duty=0, busy=0, no done.
  - Stimulus: abort high coincident with cmd_pulse in IDLE.
  - Response: move not started.
- Command while busy:
  - Stimulus: second command edge during RUN with sel_90 toggled to 0.
  - Response: target_sel stays 1 and the move completes normally.
- Async reset mid-SETTLE:
  - Stimulus: reset_n low mid-SETTLE.
  - Response: all outputs 0 immediately; after release, IDLE with no done pulse.

Source files
------------

// File: rtl/motor_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and constants for the click-driven motor positioning path.
// Targets match the position-error block; cycle constants assume the 48 MHz clock.
package motor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RUN,
      ST_SETTLE,
      ST_DONE,
      ST_FAULT
   } motor_state_e;

   localparam int TGT_90          = 87;
   localparam int TGT_180         = 174;

   localparam int DEF_TOL         = 2;
   localparam int DEF_SLOW_BAND   = 16;
   localparam int DEF_DUTY_FAST   = 255;
   localparam int DEF_DUTY_SLOW   = 96;
   localparam int DEF_PIPE_LAT    = 2;

   localparam int CLK_HZ          = 48_000_000;
   localparam int DEF_SETTLE_CYC  = 1024;
   localparam int DEF_TIMEOUT_CYC = CLK_HZ / 2;
   localparam int TMO_W           = 25;

   function automatic logic [7:0] target_of(input logic sel_90);
      return sel_90 ? 8'(TGT_90) : 8'(TGT_180);
   endfunction

endpackage

// File: rtl/motor_move_ctrl_if.sv
`timescale 1ns/1ps
// Command, error-datapath and driver signals of one positioning move.
// The controller is the slave; whoever issues moves and supplies the error is the master.
interface motor_move_ctrl_if;

   logic        command;
   logic        sel_90;
   logic        abort;
   logic [11:0] errorabs;
   logic        errorsign;
   logic        target_sel;
   logic        motor_en;
   logic        motor_dir;
   logic [7:0]  duty;
   logic        busy;
   logic        done;
   logic        fault;

   modport master (
      output command, sel_90, abort, errorabs, errorsign,
      input  target_sel, motor_en, motor_dir, duty, busy, done, fault
   );

   modport slave (
      input  command, sel_90, abort, errorabs, errorsign,
      output target_sel, motor_en, motor_dir, duty, busy, done, fault
   );

endinterface

// File: rtl/cmd_edge_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer with a registered rising-edge pulse, for asynchronous
// front-panel inputs; the pulse appears on the third clock after the raw edge.
module cmd_edge_sync (
   input  logic clk_48,
   input  logic reset_n,
   input  logic sig_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic pulse_q;

   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/motor_move_ctrl.sv
`timescale 1ns/1ps
// Sequences one positioning move: latch target, let the error pipe refresh, drive the
// motor until the error settles, with timeout fault and abort. All outputs are registered.
module motor_move_ctrl
   import motor_pkg::*;
#(
   parameter int TOL         = DEF_TOL,
   parameter int SLOW_BAND   = DEF_SLOW_BAND,
   parameter int DUTY_FAST   = DEF_DUTY_FAST,
   parameter int DUTY_SLOW   = DEF_DUTY_SLOW,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
   input logic              clk_48,
   input logic              reset_n,
   motor_move_ctrl_if.slave mv_if
);

   localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int PCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   motor_state_e     state_q, state_d;
   logic             target_sel_q, target_sel_d;
   logic             motor_en_q, motor_en_d;
   logic             motor_dir_q, motor_dir_d;
   logic [7:0]       duty_q, duty_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;
   logic [PCW-1:0]   pipe_cnt_q, pipe_cnt_d;
   logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   logic             cmd_pulse;
   logic             on_target;
   logic             in_slow_band;
   logic             tmo_hit;
   logic [TMO_W-1:0] tmo_inc;

   cmd_edge_sync u_cmd_sync (
      .clk_48  (clk_48),
      .reset_n (reset_n),
      .sig_i   (mv_if.command),
      .pulse_o (cmd_pulse)
   );

   assign on_target    = (mv_if.errorabs <= 12'(TOL));
   assign in_slow_band = (mv_if.errorabs <= 12'(SLOW_BAND));
   assign tmo_hit      = (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
   assign tmo_inc      = (&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);

   // Next-state and next-output decision; abort overrides every other transition.
   always_comb begin
      state_d      = state_q;
      target_sel_d = target_sel_q;
      motor_en_d   = motor_en_q;
      motor_dir_d  = motor_dir_q;
      duty_d       = duty_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      fault_d      = fault_q;
      pipe_cnt_d   = pipe_cnt_q;
      settle_cnt_d = settle_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;

      if (mv_if.abort) begin
         state_d    = ST_IDLE;
         motor_en_d = 1'b0;
         duty_d     = 8'd0;
         busy_d     = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_FAULT: begin
               motor_en_d = 1'b0;
               duty_d     = 8'd0;
               if (cmd_pulse) begin
                  target_sel_d = mv_if.sel_90;
                  fault_d      = 1'b0;
                  busy_d       = 1'b1;
                  pipe_cnt_d   = '0;
                  state_d      = ST_WAIT;
               end
            end
            ST_WAIT: begin
               motor_en_d = 1'b0;
               duty_d     = 8'd0;
               if (pipe_cnt_q == PCW'(PIPE_LAT - 1)) begin
                  tmo_cnt_d    = '0;
                  settle_cnt_d = '0;
                  state_d      = ST_RUN;
               end else begin
                  pipe_cnt_d = pipe_cnt_q + PCW'(1);
               end
            end
            ST_RUN: begin
               tmo_cnt_d = tmo_inc;
               if (tmo_hit) begin
                  motor_en_d = 1'b0;
                  duty_d     = 8'd0;
                  fault_d    = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ST_FAULT;
               end else if (on_target) begin
                  motor_en_d   = 1'b0;
                  duty_d       = 8'd0;
                  settle_cnt_d = '0;
                  state_d      = ST_SETTLE;
               end else begin
                  motor_en_d  = 1'b1;
                  motor_dir_d = ~mv_if.errorsign;
                  duty_d      = in_slow_band ? 8'(DUTY_SLOW) : 8'(DUTY_FAST);
               end
            end
            ST_SETTLE: begin
               motor_en_d = 1'b0;
               duty_d     = 8'd0;
               tmo_cnt_d  = tmo_inc;
               if (tmo_hit) begin
                  fault_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_FAULT;
               end else if (!on_target) begin
                  settle_cnt_d = '0;
                  state_d      = ST_RUN;
               end else if (settle_cnt_q == SCW'(SETTLE_CYC - 1)) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  settle_cnt_d = settle_cnt_q + SCW'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, outputs and counters share one register bank so every output is a flop.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         target_sel_q <= 1'b0;
         motor_en_q   <= 1'b0;
         motor_dir_q  <= 1'b0;
         duty_q       <= 8'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
         pipe_cnt_q   <= '0;
         settle_cnt_q <= '0;
         tmo_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         target_sel_q <= target_sel_d;
         motor_en_q   <= motor_en_d;
         motor_dir_q  <= motor_dir_d;
         duty_q       <= duty_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         pipe_cnt_q   <= pipe_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
      end
   end

   assign mv_if.target_sel = target_sel_q;
   assign mv_if.motor_en   = motor_en_q;
   assign mv_if.motor_dir  = motor_dir_q;
   assign mv_if.duty       = duty_q;
   assign mv_if.busy       = busy_q;
   assign mv_if.done       = done_q;
   assign mv_if.fault      = fault_q;

endmodule

// File: tb/tb_motor_move_ctrl.sv
`timescale 1ns/1ps
// Directed bench for motor_move_ctrl with a shortened timeout; inputs change and
// outputs are sampled on the falling clock edge.
module tb_motor_move_ctrl;
   import motor_pkg::*;

   localparam int TB_TIMEOUT = 5000;

   logic clk48 = 1'b0;
   logic resetN;
   int   checkCount = 0;
   int   passCount  = 0;
   int   failCount  = 0;
   int   cycles;
   int   doneSeen;
   logic cmdLvl;
   logic selLvl;

   motor_move_ctrl_if mvIf ();

   motor_move_ctrl #(
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk_48  (clk48),
      .reset_n (resetN),
      .mv_if   (mvIf.slave)
   );

   // 48 MHz-ish clock; only the cycle count matters to the checks.
   always #10 clk48 = ~clk48;

   // Hard stop in case a bounded wait is ever miscoded.
   initial begin
      #(20 * 60000);
      $display("[TB] FAIL watchdog: observed no finish expected finish before 60000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk48);
   endtask

   task automatic applyStimulus(input logic cmd, input logic sel, input logic abrt,
                                input logic [11:0] eabs, input logic esign);
      mvIf.command   = cmd;
      mvIf.sel_90    = sel;
      mvIf.abort     = abrt;
      mvIf.errorabs  = eabs;
      mvIf.errorsign = esign;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitDone(input int limit, output int n);
      n = 0;
      while (mvIf.done !== 1'b1 && n < limit) begin
         step(1);
         n++;
      end
   endtask

   initial begin
      // Reset state
      resetN = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd40, 1'b0);
      step(3);
      checkOutput("rst_target_sel", mvIf.target_sel, 0);
      checkOutput("rst_motor_en", mvIf.motor_en, 0);
      checkOutput("rst_motor_dir", mvIf.motor_dir, 0);
      checkOutput("rst_duty", mvIf.duty, 0);
      checkOutput("rst_busy", mvIf.busy, 0);
      checkOutput("rst_done", mvIf.done, 0);
      checkOutput("rst_fault", mvIf.fault, 0);
      resetN = 1'b1;
      step(2);
      checkOutput("idle_busy", mvIf.busy, 0);

      // Basic 90 move, with a second command during RUN that must be ignored
      $display("[TB] 90 move toward target %0d", target_of(1'b1));
      applyStimulus(1'b1, 1'b1, 1'b0, 12'd40, 1'b0);
      step(3);
      checkOutput("acc_busy_early", mvIf.busy, 0);
      step(1);
      checkOutput("acc_busy", mvIf.busy, 1);
      checkOutput("acc_target_sel", mvIf.target_sel, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd40, 1'b0);
      step(2);
      checkOutput("wait_motor_off", mvIf.motor_en, 0);
      step(1);
      checkOutput("run_en", mvIf.motor_en, 1);
      checkOutput("run_dir", mvIf.motor_dir, 1);
      checkOutput("run_duty_fast", mvIf.duty, 255);
      for (int v = 39; v >= 3; v--) begin
         cmdLvl = (v <= 30 && v > 25);
         selLvl = (v > 30);
         applyStimulus(cmdLvl, selLvl, 1'b0, 12'(v), 1'b0);
         step(1);
         if (v == 17) begin
            checkOutput("e17_duty", mvIf.duty, 255);
            checkOutput("e17_en", mvIf.motor_en, 1);
         end
         if (v == 16) checkOutput("e16_duty", mvIf.duty, 96);
         if (v == 20) checkOutput("busy_cmd_target_sel", mvIf.target_sel, 1);
         if (v == 3) begin
            checkOutput("e3_en", mvIf.motor_en, 1);
            checkOutput("e3_duty", mvIf.duty, 96);
            checkOutput("e3_busy", mvIf.busy, 1);
         end
         step(99);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd2, 1'b0);
      step(1);
      checkOutput("e2_en", mvIf.motor_en, 0);
      checkOutput("e2_duty", mvIf.duty, 0);
      mvIf.errorabs = 12'd0;
      waitDone(3000, cycles);
      checkOutput("basic_done_latency", cycles, 1024);
      checkOutput("basic_done", mvIf.done, 1);
      checkOutput("basic_done_busy", mvIf.busy, 0);
      checkOutput("basic_target_kept", mvIf.target_sel, 1);
      step(1);
      checkOutput("basic_done_pulse_end", mvIf.done, 0);
      checkOutput("basic_dir_held", mvIf.motor_dir, 1);

      // Overshoot during SETTLE restarts the settle count
      applyStimulus(1'b1, 1'b0, 1'b0, 12'd10, 1'b0);
      step(4);
      checkOutput("ov_busy", mvIf.busy, 1);
      checkOutput("ov_target_sel", mvIf.target_sel, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd2, 1'b0);
      step(500);
      checkOutput("ov_settle_en", mvIf.motor_en, 0);
      checkOutput("ov_settle_done", mvIf.done, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd5, 1'b1);
      step(1);
      checkOutput("ov_back_en_off", mvIf.motor_en, 0);
      step(1);
      checkOutput("ov_run_en", mvIf.motor_en, 1);
      checkOutput("ov_run_dir", mvIf.motor_dir, 0);
      checkOutput("ov_run_duty", mvIf.duty, 96);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd0, 1'b1);
      step(1);
      checkOutput("ov_zero_beyond_en", mvIf.motor_en, 0);
      waitDone(3000, cycles);
      checkOutput("ov_done_latency", cycles, 1024);
      checkOutput("ov_done_busy", mvIf.busy, 0);
      step(1);
      checkOutput("ov_done_pulse_end", mvIf.done, 0);

      // Timeout with the error held large
      applyStimulus(1'b1, 1'b0, 1'b0, 12'd100, 1'b1);
      step(4);
      checkOutput("to_busy", mvIf.busy, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd100, 1'b1);
      step(3);
      checkOutput("to_run_en", mvIf.motor_en, 1);
      checkOutput("to_run_dir", mvIf.motor_dir, 0);
      checkOutput("to_run_duty", mvIf.duty, 255);
      step(4998);
      checkOutput("to_before_fault", mvIf.fault, 0);
      checkOutput("to_before_en", mvIf.motor_en, 1);
      step(1);
      checkOutput("to_fault", mvIf.fault, 1);
      checkOutput("to_en_off", mvIf.motor_en, 0);
      checkOutput("to_duty_off", mvIf.duty, 0);
      checkOutput("to_busy_off", mvIf.busy, 0);
      checkOutput("to_no_done", mvIf.done, 0);
      step(20);
      checkOutput("to_fault_sticky", mvIf.fault, 1);

      // Restart from FAULT, then abort mid-RUN
      applyStimulus(1'b1, 1'b0, 1'b0, 12'd50, 1'b0);
      step(3);
      checkOutput("rs_fault_before_accept", mvIf.fault, 1);
      step(1);
      checkOutput("rs_busy", mvIf.busy, 1);
      checkOutput("rs_fault_cleared", mvIf.fault, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd50, 1'b0);
      step(3);
      checkOutput("rs_run_en", mvIf.motor_en, 1);
      checkOutput("rs_run_dir", mvIf.motor_dir, 1);
      step(7);
      applyStimulus(1'b0, 1'b0, 1'b1, 12'd50, 1'b0);
      step(1);
      checkOutput("ab_en", mvIf.motor_en, 0);
      checkOutput("ab_duty", mvIf.duty, 0);
      checkOutput("ab_busy", mvIf.busy, 0);
      checkOutput("ab_done", mvIf.done, 0);
      checkOutput("ab_fault", mvIf.fault, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'd50, 1'b0);
      step(5);
      checkOutput("ab_stays_idle", mvIf.busy, 0);
      checkOutput("ab_stays_off", mvIf.motor_en, 0);

      // Abort coincident with the accepted command pulse
      applyStimulus(1'b1, 1'b1, 1'b0, 12'd50, 1'b0);
      step(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 12'd50, 1'b0);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 12'd50, 1'b0);
      checkOutput("abcmd_busy", mvIf.busy, 0);
      checkOutput("abcmd_target_sel", mvIf.target_sel, 0);
      step(5);
      checkOutput("abcmd_not_started", mvIf.busy, 0);
      checkOutput("abcmd_en", mvIf.motor_en, 0);
      mvIf.command = 1'b0;
      step(3);

      // Asynchronous reset in the middle of SETTLE
      applyStimulus(1'b1, 1'b1, 1'b0, 12'd1, 1'b0);
      step(4);
      checkOutput("ar_busy", mvIf.busy, 1);
      checkOutput("ar_target_sel", mvIf.target_sel, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'd1, 1'b0);
      step(50);
      checkOutput("ar_settle_busy", mvIf.busy, 1);
      #3;
      resetN = 1'b0;
      #1;
      checkOutput("ar_busy_drop", mvIf.busy, 0);
      checkOutput("ar_target_sel_drop", mvIf.target_sel, 0);
      checkOutput("ar_dir_drop", mvIf.motor_dir, 0);
      checkOutput("ar_done_drop", mvIf.done, 0);
      checkOutput("ar_fault_drop", mvIf.fault, 0);
      @(negedge clk48);
      resetN = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 1100; i++) begin
         step(1);
         if (mvIf.done === 1'b1) doneSeen++;
      end
      checkOutput("ar_no_done", doneSeen, 0);
      checkOutput("ar_idle_busy", mvIf.busy, 0);
      checkOutput("ar_idle_fault", mvIf.fault, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
